// File: rtl/trng_byte_reader_if.sv
// Byte stream carrying sampled TRNG bytes from the reader to a consumer.
// Show-ahead valid/ready: data is the FIFO head whenever valid is high.
interface trng_byte_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/trng_byte_reader.sv
// Decimating sampler for the trng_core byte bus: warm-up discard after enable,
// FIFO buffering with show-ahead stream output, and sticky/counted overflow drops.
module trng_byte_reader #(
  parameter int unsigned SAMPLE_DIV     = 500,
  parameter int unsigned WARMUP_SAMPLES = 4,
  parameter int unsigned FIFO_AW        = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [7:0]             rnddata,
  trng_byte_reader_if.master     m_stream,
  output logic [FIFO_AW:0]       fifo_level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  input  logic                   clr_drop
);

  localparam int unsigned Depth    = 2 ** FIFO_AW;
  localparam int unsigned DivW     = $clog2(SAMPLE_DIV);
  localparam int unsigned WarmW    = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam int unsigned WarmLast = (WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0;

  localparam logic [DivW-1:0]  DivLastVal  = DivW'(SAMPLE_DIV - 1);
  localparam logic [WarmW-1:0] WarmLastVal = WarmW'(WarmLast);
  localparam logic [FIFO_AW:0] FullLevel   = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [WarmW-1:0]  warm_q, warm_d;
  logic              tick;
  logic              sample_push;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [7:0]         hold_q, hold_d;
  logic               full, empty, pop, push_ok, drop;

  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]        drop_base;

  // ---------------------------------------------------------------------------
  // Sample-rate divider and enable/warm-up sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    tick = (state_q != StIdle) && (div_q == DivLastVal);
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    warm_d      = warm_q;
    sample_push = 1'b0;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        div_d  = '0;
        warm_d = '0;
        if (en) begin
          state_d = (WARMUP_SAMPLES > 0) ? StWarmup : StRun;
        end
      end
      StWarmup: begin
        // Warm-up ticks only advance the counter; the sample is thrown away.
        if (tick) begin
          if (warm_q == WarmLastVal) begin
            state_d = StRun;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      StRun: begin
        sample_push = tick;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Disable wins over everything else, but a coincident tick above still acts.
    if (!en) begin
      state_d = StIdle;
      div_d   = '0;
      warm_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      div_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      warm_q  <= warm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    full    = (level_q == FullLevel);
    empty   = (level_q == '0);
    pop     = !empty && m_stream.m_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    push_ok = sample_push && (!full || pop);
    drop    = sample_push && full && !pop;
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end
    hold_d = empty ? hold_q : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rnddata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_base  = clr_drop ? 16'h0000 : drop_cnt_q;
    drop_cnt_d = (drop && (drop_base != 16'hFFFF)) ? drop_base + 16'd1 : drop_base;
    overflow_d = (overflow_q && !clr_drop) || drop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // When empty, m_data keeps showing the last head value instead of stale RAM.
  assign m_stream.m_valid = !empty;
  assign m_stream.m_data  = empty ? hold_q : mem_q[rd_ptr_q];
  assign fifo_level       = level_q;
  assign overflow         = overflow_q;
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_trng_byte_reader.sv
// Directed-sequence bench for trng_byte_reader with random data/ready stimulus,
// checked every relevant cycle against a queue-based reference model.
module tb_trng_byte_reader;

  localparam int DIV   = 500;
  localparam int WARM  = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          clr_drop = 1'b0;
  logic [7:0]    rnddata = 8'h00;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic [15:0]   drop_cnt;

  trng_byte_reader_if s_if ();

  trng_byte_reader #(
    .SAMPLE_DIV     (DIV),
    .WARMUP_SAMPLES (WARM),
    .FIFO_AW        (AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .rnddata    (rnddata),
    .m_stream   (s_if),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .clr_drop   (clr_drop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a byte queue plus "cycles since enable" and "ticks since enable".
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_active;
  int         m_cyc;
  int         m_ticks;
  bit         m_ovf;
  int         m_drops;
  bit         m_tick;
  bit         m_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = 8'h00;
    m_active = 1'b0;
    m_cyc    = 0;
    m_ticks  = 0;
    m_ovf    = 1'b0;
    m_drops  = 0;
    m_tick   = 1'b0;
    m_pop    = 1'b0;
  endtask

  task automatic model_edge();
    bit push;
    bit drop;
    m_tick = m_active && ((m_cyc % DIV) == DIV - 1);
    push   = m_tick && (m_ticks >= WARM);
    m_pop  = (mq.size() != 0) && s_if.m_ready;
    if (mq.size() != 0) m_last = mq[0];
    drop   = push && (mq.size() == DEPTH) && !m_pop;
    if (m_pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back(rnddata);
    if (clr_drop) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (!en) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_ticks  = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_cyc    = 0;
      m_ticks  = 0;
    end else begin
      m_cyc++;
      if (m_tick) m_ticks++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ed;
    ed = (mq.size() != 0) ? mq[0] : m_last;
    chk({tag, ".valid"}, 32'(s_if.m_valid), 32'(mq.size() != 0));
    chk({tag, ".data"}, 32'(s_if.m_data), 32'(ed));
    chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic step(input bit e, input bit r, input bit c, input logic [7:0] d);
    en          = e;
    s_if.m_ready = r;
    clr_drop    = c;
    rnddata     = d;
    @(posedge clk);
    model_edge();
    #1;
    if (m_tick || m_pop || c || ($urandom_range(0, 31) == 0)) check_all("step");
  endtask

  initial begin
    int  first;
    int  cnt;
    bit  found;

    s_if.m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", 32'(s_if.m_valid), 32'd0);
    chk("reset.data", 32'(s_if.m_data), 32'd0);
    chk("reset.level", 32'(fifo_level), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Warm-up then streaming with a ramp; first byte appears 2501 cycles after en.
    first = 0;
    for (int n = 1; n <= 3100; n++) begin
      step(1'b1, 1'b1, 1'b0, 8'(n));
      if (first == 0 && s_if.m_valid === 1'b1) first = n;
      if (n == 2501) chk("t2_tick5_data", 32'(s_if.m_data), 32'd197);
      if (n == 3001) chk("t2_tick6_data", 32'(s_if.m_data), 32'd185);
    end
    chk("t2_first_valid", 32'(first), 32'd2501);

    // Consumer stalled for 20 RUN ticks: 16 stored, 4 dropped.
    cnt = 0;
    for (int n = 0; n < 12000 && cnt < 20; n++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom));
      if (m_tick) cnt++;
    end
    chk("t3_ticks_seen", 32'(cnt), 32'd20);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd4);

    // Full FIFO, pop coincident with tick: push accepted, no new drop.
    for (int n = 0; n < DIV && (m_cyc % DIV) != DIV - 1; n++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'($urandom));
    chk("t4_level", 32'(fifo_level), 32'd16);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd4);
    check_all("t4");

    // Drain with sampling off; model verifies order and last-value hold.
    for (int n = 0; n < 40; n++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("drain_level", 32'(fifo_level), 32'd0);
    check_all("drain");

    // Random ready/clear traffic.
    for (int n = 0; n < 4000; n++)
      step(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0), 8'($urandom));

    // clr_drop coincident with a drop, then a plain clear.
    for (int n = 0; n < 20000 && !(mq.size() == DEPTH && m_active && (m_cyc % DIV) == DIV - 1);
         n++)
      step(1'b1, 1'b0, 1'b0, 8'($urandom));
    found = (mq.size() == DEPTH) && m_active && ((m_cyc % DIV) == DIV - 1);
    chk("t5_reached_full_tick", 32'(found), 32'd1);
    step(1'b1, 1'b0, 1'b1, 8'($urandom));
    chk("t5_clr_drop_ovf", 32'(overflow), 32'd1);
    chk("t5_clr_drop_cnt", 32'(drop_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b1, 8'($urandom));
    chk("t5_clr_ovf", 32'(overflow), 32'd0);
    chk("t5_clr_cnt", 32'(drop_cnt), 32'd0);

    // en toggled mid-warm-up with level 3: warm-up restarts in full.
    for (int n = 0; n < 13; n++) step(1'b0, 1'b1, 1'b0, 8'($urandom));
    chk("t6_level_start", 32'(fifo_level), 32'd3);
    for (int n = 0; n < 1200; n++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int n = 1; n <= 2600; n++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom));
      if (n == 2400) chk("t6_warmup_discard", 32'(fifo_level), 32'd3);
    end
    chk("t6_first_push", 32'(fifo_level), 32'd4);

    // Asynchronous reset with data in flight.
    for (int n = 0; n < 1000 && mq.size() < 5; n++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    chk("t1_level_before", 32'(fifo_level), 32'd5);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("t1_valid", 32'(s_if.m_valid), 32'd0);
    chk("t1_data", 32'(s_if.m_data), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
